mil1553_word_tx: RTL and testbench

- Manchester II bi-phase transmitter for MIL-STD-1553 words; the transmit counterpart of the word decoder inside the 1553 core.
- Accepts a 16-bit word plus a word-type strobe: command/status (CSW) or data (DW).
- Emits sync, 16 data bits MSB-first and odd parity on a differential pair (tx_data/tx_data_n).
- Runs on the 2 MHz encode clock: one enc_clk cycle = one half-bit (0.5 us).
- Has a one-deep holding buffer, so a BC/RT sequencer can queue the next word while the current one shifts out.

---
 rtl/mil1553_word_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_mil1553_word_tx.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mil1553_word_tx.sv
// MIL-STD-1553 Manchester II word transmitter.
// Takes a 16-bit word and a word-type strobe. Sends sync, 16 data bits MSB
// first, and odd parity on a differential pair. A one-deep holding buffer
// lets the sequencer queue the next word while the current word shifts out.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | bus quiet; launches the buffered word as soon as one exists
// SYNC   | 6 half-bits of sync (CSW 111000, DW 000111)
// DATA   | 32 half-bits, bit 15 first, 1 -> "10", 0 -> "01"
// PARITY | 2 half-bits of odd parity, same encoding as DATA
// GAP    | GAP_HALFBITS quiet half-bits, then SYNC (buffer full) or IDLE
//
// Bus-facing outputs are registered from the current state and counter, so
// the bus lags the state register by one cycle. A strobe sampled at edge N
// therefore shows its first sync half-bit after edge N+2.

module mil1553_word_tx #(
   parameter int GAP_HALFBITS = 8
) (
   input  logic        enc_clk,
   input  logic        reset_slow,
   input  logic [15:0] tx_dword,
   input  logic        tx_csw,
   input  logic        tx_dw,
   output logic        tx_data,
   output logic        tx_data_n,
   output logic        tx_dval,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx_ovf,
   output logic        tx_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   localparam bit         HAS_GAP    = (GAP_HALFBITS > 0);
   localparam logic [7:0] GAP_RELOAD = HAS_GAP ? 8'(GAP_HALFBITS - 1) : 8'd0;

   localparam logic [5:0] SYNC_RELOAD   = 6'd5;
   localparam logic [5:0] DATA_RELOAD   = 6'd31;
   localparam logic [5:0] PARITY_RELOAD = 6'd1;

   state_t      state_q, state_d;
   logic [5:0]  hb_cnt_q, hb_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0] sh_q, sh_d;
   logic        cur_csw_q, cur_csw_d;
   logic        par_q, par_d;

   logic [15:0] buf_word_q, buf_word_d;
   logic        buf_csw_q, buf_csw_d;
   logic        buf_full_q, buf_full_d;

   logic        tx_data_q, tx_data_d;
   logic        tx_data_n_q, tx_data_n_d;
   logic        tx_dval_q, tx_dval_d;
   logic        tx_busy_q, tx_busy_d;
   logic        last_hb_q, last_hb_d;
   logic        tx_done_q, tx_done_d;
   logic        tx_ovf_q, tx_ovf_d;
   logic        tx_err_q, tx_err_d;

   logic        req_one;
   logic        req_both;
   logic        load;
   logic        active;
   logic        hb_bit;

   assign req_one  = tx_csw ^ tx_dw;
   assign req_both = tx_csw & tx_dw;

   // Next-state logic: FSM sequencing, down-counters, shifter and holding buffer.
   always_comb begin
      state_d    = state_q;
      hb_cnt_d   = hb_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      sh_d       = sh_q;
      cur_csw_d  = cur_csw_q;
      par_d      = par_q;
      buf_word_d = buf_word_q;
      buf_csw_d  = buf_csw_q;
      buf_full_d = buf_full_q;
      load       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (buf_full_q) begin
               load = 1'b1;
            end
         end
         S_SYNC: begin
            if (hb_cnt_q == 6'd0) begin
               state_d  = S_DATA;
               hb_cnt_d = DATA_RELOAD;
            end else begin
               hb_cnt_d = hb_cnt_q - 6'd1;
            end
         end
         S_DATA: begin
            if (hb_cnt_q == 6'd0) begin
               state_d  = S_PARITY;
               hb_cnt_d = PARITY_RELOAD;
            end else begin
               hb_cnt_d = hb_cnt_q - 6'd1;
               // even count = second half of a bit; advance to the next bit
               if (!hb_cnt_q[0]) begin
                  sh_d = {sh_q[14:0], 1'b0};
               end
            end
         end
         S_PARITY: begin
            if (hb_cnt_q == 6'd0) begin
               if (HAS_GAP) begin
                  state_d   = S_GAP;
                  gap_cnt_d = GAP_RELOAD;
               end else if (buf_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               hb_cnt_d = hb_cnt_q - 6'd1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               // going straight to SYNC keeps word spacing at 40+GAP cycles
               if (buf_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load) begin
         state_d    = S_SYNC;
         hb_cnt_d   = SYNC_RELOAD;
         sh_d       = buf_word_q;
         cur_csw_d  = buf_csw_q;
         par_d      = ~^buf_word_q;
         buf_full_d = 1'b0;
      end

      // load needs a full buffer and accept an empty one, so they never collide
      if (req_one && !buf_full_q) begin
         buf_word_d = tx_dword;
         buf_csw_d  = tx_csw;
         buf_full_d = 1'b1;
      end
   end

   // Output decode: half-bit value for the current state, registered next edge.
   always_comb begin
      active = (state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_PARITY);
      hb_bit = 1'b0;
      case (state_q)
         S_SYNC:   hb_bit = cur_csw_q ? (hb_cnt_q >= 6'd3) : (hb_cnt_q < 6'd3);
         S_DATA:   hb_bit = hb_cnt_q[0] ? sh_q[15] : ~sh_q[15];
         S_PARITY: hb_bit = hb_cnt_q[0] ? par_q : ~par_q;
         default:  hb_bit = 1'b0;
      endcase

      tx_data_d   = active & hb_bit;
      tx_data_n_d = active & ~hb_bit;
      tx_dval_d   = active;
      tx_busy_d   = (state_q != S_IDLE) || buf_full_q;
      last_hb_d   = (state_q == S_PARITY) && (hb_cnt_q == 6'd0);
      // one extra stage so the pulse lands after the last parity half-bit
      tx_done_d   = last_hb_q;
      tx_ovf_d    = req_one && buf_full_q;
      tx_err_d    = req_both;
   end

   // State, buffer and output registers with synchronous reset.
   always_ff @(posedge enc_clk) begin
      if (reset_slow) begin
         state_q     <= S_IDLE;
         hb_cnt_q    <= 6'd0;
         gap_cnt_q   <= 8'd0;
         sh_q        <= 16'd0;
         cur_csw_q   <= 1'b0;
         par_q       <= 1'b0;
         buf_word_q  <= 16'd0;
         buf_csw_q   <= 1'b0;
         buf_full_q  <= 1'b0;
         tx_data_q   <= 1'b0;
         tx_data_n_q <= 1'b0;
         tx_dval_q   <= 1'b0;
         tx_busy_q   <= 1'b0;
         last_hb_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         tx_ovf_q    <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hb_cnt_q    <= hb_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sh_q        <= sh_d;
         cur_csw_q   <= cur_csw_d;
         par_q       <= par_d;
         buf_word_q  <= buf_word_d;
         buf_csw_q   <= buf_csw_d;
         buf_full_q  <= buf_full_d;
         tx_data_q   <= tx_data_d;
         tx_data_n_q <= tx_data_n_d;
         tx_dval_q   <= tx_dval_d;
         tx_busy_q   <= tx_busy_d;
         last_hb_q   <= last_hb_d;
         tx_done_q   <= tx_done_d;
         tx_ovf_q    <= tx_ovf_d;
         tx_err_q    <= tx_err_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_data_n = tx_data_n_q;
   assign tx_dval   = tx_dval_q;
   assign tx_busy   = tx_busy_q;
   assign tx_done   = tx_done_q;
   assign tx_ovf    = tx_ovf_q;
   assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_mil1553_word_tx.sv
// Bench for mil1553_word_tx. A word-level reference model predicts, for
// every clock edge, the seven outputs from each accepted word's acceptance
// edge and launch edge; each scenario task compares the DUT against it.

module tb_mil1553_word_tx;

   localparam int GAP = 8;

   logic        enc_clk = 1'b0;
   logic        reset_slow = 1'b0;
   logic [15:0] tx_dword = 16'h0000;
   logic        tx_csw = 1'b0;
   logic        tx_dw = 1'b0;
   logic        tx_data, tx_data_n, tx_dval, tx_busy, tx_done, tx_ovf, tx_err;

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          acc;
      int          launch;
      logic [15:0] w;
      bit          csw;
   } word_t;

   word_t wq[$];

   mil1553_word_tx #(.GAP_HALFBITS(GAP)) dut (
      .enc_clk    (enc_clk),
      .reset_slow (reset_slow),
      .tx_dword   (tx_dword),
      .tx_csw     (tx_csw),
      .tx_dw      (tx_dw),
      .tx_data    (tx_data),
      .tx_data_n  (tx_data_n),
      .tx_dval    (tx_dval),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_ovf     (tx_ovf),
      .tx_err     (tx_err)
   );

   always #5 enc_clk = ~enc_clk;

   // Half-bit k (0..39) of a word as it should appear on tx_data.
   function automatic logic hb_val(input logic [15:0] w, input bit csw, input int k);
      logic p;
      logic b;
      if (k < 6) return (csw == (k < 3)) ? 1'b1 : 1'b0;
      if (k < 38) begin
         b = w[15 - (k - 6) / 2];
         return ((k - 6) % 2 == 0) ? b : ~b;
      end
      p = ($countones(w) % 2 == 0) ? 1'b1 : 1'b0;
      return (k == 38) ? p : ~p;
   endfunction

   // Drive one cycle of inputs, advance the model, and sample the DUT.
   // Output vector: {data, data_n, dval, busy, done, ovf, err}.
   task automatic tick(input logic csw, input logic dw, input logic [15:0] w,
                       input logic rst, output logic [6:0] obs, output logic [6:0] exp);
      logic d, dv, bz, dn, ov, er, full;
      word_t nw;
      @(negedge enc_clk);
      tx_csw     = csw;
      tx_dw      = dw;
      tx_dword   = w;
      reset_slow = rst;
      @(posedge enc_clk);
      cyc++;
      d = 1'b0; dv = 1'b0; bz = 1'b0; dn = 1'b0; ov = 1'b0; er = 1'b0; full = 1'b0;
      if (rst) begin
         wq.delete();
      end else begin
         foreach (wq[i]) begin
            int k;
            k = cyc - wq[i].launch;
            if (wq[i].acc < cyc && wq[i].launch >= cyc + 1) full = 1'b1;
            if (k >= 0 && k < 40) begin
               dv = 1'b1;
               d  = hb_val(wq[i].w, wq[i].csw, k);
            end
            if (k == 40) dn = 1'b1;
            if (cyc >= wq[i].acc + 1 && cyc <= wq[i].launch + 39 + GAP) bz = 1'b1;
         end
         if (csw && dw) begin
            er = 1'b1;
         end else if (csw != dw) begin
            if (full) begin
               ov = 1'b1;
            end else begin
               nw.acc    = cyc;
               nw.w      = w;
               nw.csw    = csw;
               nw.launch = cyc + 2;
               if (wq.size() > 0 && wq[$].launch + 40 + GAP > nw.launch)
                  nw.launch = wq[$].launch + 40 + GAP;
               wq.push_back(nw);
            end
         end
      end
      exp = {d, dv ? ~d : 1'b0, dv, bz, dn, ov, er};
      #1;
      obs = {tx_data, tx_data_n, tx_dval, tx_busy, tx_done, tx_ovf, tx_err};
   endtask

   task automatic test_reset();
      logic [6:0] o, e;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b1, o, e);
         n_cmp++;
         if (o !== 7'b0000000) begin
            n_err++;
            $display("FAIL reset_outputs cyc=%0d got=%b want=%b", cyc, o, 7'b0000000);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, o, e);
         end
      end
   endtask

   task automatic test_csw_zero();
      logic [6:0] o, e;
      int s0, rise, done_c, idle_c, dv_cnt;
      rise = -1; done_c = -1; idle_c = -1; dv_cnt = 0;
      tick(1'b1, 1'b0, 16'h0000, 1'b0, o, e);
      s0 = cyc;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL csw0_wave cyc=%0d got=%b want=%b", cyc, o, e);
      end
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, 1'b0, 16'($urandom), 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL csw0_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
         if (o[4]) dv_cnt++;
         if (rise < 0 && o[4]) rise = cyc;
         if (done_c < 0 && o[2]) done_c = cyc;
         if (done_c >= 0 && idle_c < 0 && !o[3]) idle_c = cyc;
      end
      n_cmp++;
      if (rise - s0 !== 2) begin
         n_err++;
         $display("FAIL csw0_latency got=%0d want=2", rise - s0);
      end
      n_cmp++;
      if (dv_cnt !== 40) begin
         n_err++;
         $display("FAIL csw0_dval_len got=%0d want=40", dv_cnt);
      end
      n_cmp++;
      if (done_c - rise !== 40) begin
         n_err++;
         $display("FAIL csw0_done_pos got=%0d want=40", done_c - rise);
      end
      n_cmp++;
      if (idle_c - done_c !== GAP) begin
         n_err++;
         $display("FAIL csw0_busy_drop got=%0d want=%0d", idle_c - done_c, GAP);
      end
   endtask

   task automatic test_dw_patterns();
      logic [6:0]  o, e;
      logic [15:0] pats [2];
      logic [1:0]  par_hb [2];
      logic [39:0] cap;
      pats[0] = 16'hFFFF; par_hb[0] = 2'b10;
      pats[1] = 16'h0001; par_hb[1] = 2'b01;
      for (int p = 0; p < 2; p++) begin
         cap = '0;
         tick(1'b0, 1'b1, pats[p], 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL dw_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
         for (int i = 0; i < 52; i++) begin
            tick(1'b0, 1'b0, 16'h0000, 1'b0, o, e);
            n_cmp++;
            if (o !== e) begin
               n_err++;
               $display("FAIL dw_wave cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (o[4]) cap = {cap[38:0], o[6]};
         end
         n_cmp++;
         if (cap[39:34] !== 6'b000111) begin
            n_err++;
            $display("FAIL dw_sync pat=%h got=%b want=000111", pats[p], cap[39:34]);
         end
         n_cmp++;
         if (cap[1:0] !== par_hb[p]) begin
            n_err++;
            $display("FAIL dw_parity pat=%h got=%b want=%b", pats[p], cap[1:0], par_hb[p]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] o, e;
      int s0, nxt, ovf_cnt, busy_low;
      int rises[$];
      logic prev_dv;
      ovf_cnt = 0; busy_low = 0; prev_dv = 1'b0;
      tick(1'b0, 1'b1, 16'hA5A5, 1'b0, o, e);
      s0 = cyc;
      for (int i = 0; i < 110; i++) begin
         nxt = cyc + 1;
         if (nxt == s0 + 12)
            tick(1'b1, 1'b0, 16'h1234, 1'b0, o, e);
         else if (nxt == s0 + 22)
            tick(1'b0, 1'b1, 16'hBEEF, 1'b0, o, e);
         else
            tick(1'b0, 1'b0, 16'h0000, 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL b2b_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
         if (o[4] && !prev_dv) rises.push_back(cyc);
         prev_dv = o[4];
         if (o[1]) ovf_cnt++;
         if (cyc > s0 && cyc <= s0 + 2 + 48 + 39 && !o[3]) busy_low++;
      end
      n_cmp++;
      if (rises.size() !== 2) begin
         n_err++;
         $display("FAIL b2b_word_count got=%0d want=2", rises.size());
      end else begin
         n_cmp++;
         if (rises[1] - rises[0] !== 40 + GAP) begin
            n_err++;
            $display("FAIL b2b_spacing got=%0d want=%0d", rises[1] - rises[0], 40 + GAP);
         end
      end
      n_cmp++;
      if (ovf_cnt !== 1) begin
         n_err++;
         $display("FAIL b2b_ovf_pulses got=%0d want=1", ovf_cnt);
      end
      n_cmp++;
      if (busy_low !== 0) begin
         n_err++;
         $display("FAIL b2b_busy_gap got=%0d want=0", busy_low);
      end
   endtask

   task automatic test_err();
      logic [6:0] o, e;
      int err_cnt, act_cnt;
      err_cnt = 0; act_cnt = 0;
      tick(1'b1, 1'b1, 16'h5555, 1'b0, o, e);
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL err_wave cyc=%0d got=%b want=%b", cyc, o, e);
      end
      if (o[0]) err_cnt++;
      if (o[4] || o[3]) act_cnt++;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b0, 16'h0000, 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL err_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
         if (o[0]) err_cnt++;
         if (o[4] || o[3]) act_cnt++;
      end
      n_cmp++;
      if (err_cnt !== 1) begin
         n_err++;
         $display("FAIL err_pulse got=%0d want=1", err_cnt);
      end
      n_cmp++;
      if (act_cnt !== 0) begin
         n_err++;
         $display("FAIL err_no_activity got=%0d want=0", act_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] o, e;
      int s0, nxt, rst_c, late_act;
      rst_c = -1; late_act = 0;
      tick(1'b0, 1'b1, 16'h5A3C, 1'b0, o, e);
      s0 = cyc;
      for (int i = 0; i < 80; i++) begin
         nxt = cyc + 1;
         if (nxt == s0 + 7)
            tick(1'b1, 1'b0, 16'hC0DE, 1'b0, o, e);
         else if (nxt == s0 + 22)
            tick(1'b0, 1'b0, 16'h0000, 1'b1, o, e);
         else
            tick(1'b0, 1'b0, 16'h0000, 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL rstmid_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
         if (nxt == s0 + 22) begin
            rst_c = cyc;
            n_cmp++;
            if (o !== 7'b0000000) begin
               n_err++;
               $display("FAIL rstmid_zero got=%b want=%b", o, 7'b0000000);
            end
         end else if (rst_c >= 0 && (o[4] || o[3] || o[2])) begin
            late_act++;
         end
      end
      n_cmp++;
      if (late_act !== 0) begin
         n_err++;
         $display("FAIL rstmid_no_resume got=%0d want=0", late_act);
      end
   endtask

   task automatic test_random();
      logic [6:0] o, e;
      int r;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 199));
         if (r < 1)
            tick(1'b0, 1'b0, 16'($urandom), 1'b1, o, e);
         else if (r < 16)
            tick(1'b1, 1'b0, 16'($urandom), 1'b0, o, e);
         else if (r < 31)
            tick(1'b0, 1'b1, 16'($urandom), 1'b0, o, e);
         else if (r < 34)
            tick(1'b1, 1'b1, 16'($urandom), 1'b0, o, e);
         else
            tick(1'b0, 1'b0, 16'($urandom), 1'b0, o, e);
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL random_wave cyc=%0d got=%b want=%b", cyc, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_csw_zero();
      test_dw_patterns();
      test_back_to_back();
      test_err();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
